mreq_arbiter: RTL and testbench

//  Shares the single memory-request (MREQ) port of the command transmitter and the

---
 rtl/mreq_arbiter.sv | 146 ++++++++++++++
 tb/tb_mreq_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mreq_arbiter.sv
// mreq_arbiter: round-robin sharing of one downstream MREQ port between NREQ requesters.
// Build macro MREQ_ARB_FIXED_PRIO_EN pins the priority pointer at 0 (fixed lowest-index priority).
module mreq_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ-1:0]      i_req_wr,
    input  logic [2*NREQ-1:0]    i_req_wsize,
    input  logic [NREQ-1:0]      i_req_aincr,
    input  logic [8*NREQ-1:0]    i_req_size,
    input  logic [32*NREQ-1:0]   i_req_addr,
    output logic                 o_mreq_valid,
    input  logic                 i_mreq_ready,
    output logic                 o_mreq_wr,
    output logic [1:0]           o_mreq_wsize,
    output logic                 o_mreq_aincr,
    output logic [7:0]           o_mreq_size,
    output logic [31:0]          o_mreq_addr,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_busy
);
    localparam int unsigned IW = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   gnt_idx_q;
    logic [IW-1:0]   ptr_q;
    logic [NREQ-1:0] grant_q;
    logic            busy_q;

    // Requester buses widened to the 4-requester maximum so a 2-bit index selects exactly.
    logic [3:0]      valid_ext;
    logic [3:0]      wr_ext;
    logic [7:0]      wsize_ext;
    logic [3:0]      aincr_ext;
    logic [31:0]     size_ext;
    logic [127:0]    addr_ext;

    assign valid_ext = 4'(i_req_valid);
    assign wr_ext    = 4'(i_req_wr);
    assign wsize_ext = 8'(i_req_wsize);
    assign aincr_ext = 4'(i_req_aincr);
    assign size_ext  = 32'(i_req_size);
    assign addr_ext  = 128'(i_req_addr);

    logic            gnt_ok;
    logic            active;
    logic            sel_valid;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [3:0]      pick_oh;
    logic [IW-1:0]   start;
    logic [IW-1:0]   ptr_nxt;
    logic [3:0]      ready_ext;

    assign gnt_ok    = (32'(gnt_idx_q) < NREQ);
    assign active    = (state_q == ST_GRANT) && gnt_ok;
    assign sel_valid = valid_ext[gnt_idx_q];

    // Rotating scan: first valid requester at or after the priority pointer.
    always_comb begin
        logic [IW-1:0] idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        start      = (32'(ptr_q) < NREQ) ? ptr_q : '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IW'((32'(start) + k) % NREQ);
            if (!pick_found && valid_ext[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
        pick_oh = 4'b0001 << pick_idx;
    end

`ifdef MREQ_ARB_FIXED_PRIO_EN
    assign ptr_nxt = '0;
`else
    assign ptr_nxt = (gnt_idx_q == IW'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;
`endif

    always_comb begin
        ready_ext = '0;
        if (active) begin
            ready_ext[gnt_idx_q] = i_mreq_ready;
        end
    end

    assign o_req_ready  = ready_ext[NREQ-1:0];
    assign o_mreq_valid = active && sel_valid;
    assign o_mreq_wr    = active ? wr_ext[gnt_idx_q] : 1'b0;
    assign o_mreq_wsize = active ? wsize_ext[{gnt_idx_q, 1'b0} +: 2] : '0;
    assign o_mreq_aincr = active ? aincr_ext[gnt_idx_q] : 1'b0;
    assign o_mreq_size  = active ? size_ext[{gnt_idx_q, 3'b000} +: 8] : '0;
    assign o_mreq_addr  = active ? addr_ext[{gnt_idx_q, 5'b00000} +: 32] : '0;
    assign o_grant      = grant_q;
    assign o_busy       = busy_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_q   <= ST_GRANT;
                        gnt_idx_q <= pick_idx;
                        grant_q   <= pick_oh[NREQ-1:0];
                        busy_q    <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!gnt_ok) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (!sel_valid || i_mreq_ready) begin
                        // Completed handshake and requester abort both release and rotate.
                        state_q <= ST_IDLE;
                        ptr_q   <= ptr_nxt;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mreq_arbiter.sv
// Bench for mreq_arbiter: an NREQ=2 and an NREQ=3 instance checked every cycle against a
// transaction-level arbitration model, plus directed scenarios with literal expectations.
module tb_mreq_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [1:0]  a_valid, a_ready, a_wr, a_aincr, a_grant;
    logic [3:0]  a_wsize;
    logic [15:0] a_size;
    logic [63:0] a_addr;
    logic        a_mvalid, a_mready, a_mwr, a_maincr, a_busy;
    logic [1:0]  a_mwsize;
    logic [7:0]  a_msize;
    logic [31:0] a_maddr;

    logic [2:0]  b_valid, b_ready, b_wr, b_aincr, b_grant;
    logic [5:0]  b_wsize;
    logic [23:0] b_size;
    logic [95:0] b_addr;
    logic        b_mvalid, b_mready, b_mwr, b_maincr, b_busy;
    logic [1:0]  b_mwsize;
    logic [7:0]  b_msize;
    logic [31:0] b_maddr;

    mreq_arbiter #(.NREQ(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req_wr(a_wr),
        .i_req_wsize(a_wsize), .i_req_aincr(a_aincr), .i_req_size(a_size),
        .i_req_addr(a_addr), .o_mreq_valid(a_mvalid), .i_mreq_ready(a_mready),
        .o_mreq_wr(a_mwr), .o_mreq_wsize(a_mwsize), .o_mreq_aincr(a_maincr),
        .o_mreq_size(a_msize), .o_mreq_addr(a_maddr), .o_grant(a_grant), .o_busy(a_busy)
    );

    mreq_arbiter #(.NREQ(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_wr(b_wr),
        .i_req_wsize(b_wsize), .i_req_aincr(b_aincr), .i_req_size(b_size),
        .i_req_addr(b_addr), .o_mreq_valid(b_mvalid), .i_mreq_ready(b_mready),
        .o_mreq_wr(b_mwr), .o_mreq_wsize(b_mwsize), .o_mreq_aincr(b_maincr),
        .o_mreq_size(b_msize), .o_mreq_addr(b_maddr), .o_grant(b_grant), .o_busy(b_busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who holds the port and which requester has priority next.
    typedef struct {
        bit          busy;
        int unsigned g;
        int unsigned ptr;
    } mdl_t;

    typedef struct {
        logic        busy;
        logic [3:0]  grant;
        logic        mvalid;
        logic [3:0]  ready;
        logic        wr;
        logic [1:0]  wsize;
        logic        aincr;
        logic [7:0]  size;
        logic [31:0] addr;
    } exp_t;

    mdl_t ma = '{busy: 1'b0, g: 0, ptr: 0};
    mdl_t mb = '{busy: 1'b0, g: 0, ptr: 0};
    int hs_a[$];
    int gq_a[$];

    function automatic logic bit_of(logic [3:0] v, int unsigned i);
        return |((v >> i) & 4'd1);
    endfunction

    function automatic mdl_t step(mdl_t s, int unsigned n, logic r, logic [3:0] v, logic mr);
        mdl_t t = s;
        logic [3:0] mask = 4'((32'd1 << n) - 1);
        if (r) begin
            t.busy = 1'b0; t.g = 0; t.ptr = 0;
        end else if (!t.busy) begin
            if ((v & mask) != 4'd0) begin
                for (int unsigned k = n; k > 0; k--) begin
                    if (bit_of(v, (t.ptr + k - 1) % n)) t.g = (t.ptr + k - 1) % n;
                end
                t.busy = 1'b1;
            end
        end else if (!bit_of(v, t.g) || mr) begin
            t.busy = 1'b0;
`ifdef MREQ_ARB_FIXED_PRIO_EN
            t.ptr = 0;
`else
            t.ptr = (t.g + 1) % n;
`endif
        end
        return t;
    endfunction

    function automatic exp_t expect_out(mdl_t s, logic [3:0] v, logic [3:0] wr, logic [7:0] ws,
                                        logic [3:0] ai, logic [31:0] sz, logic [127:0] ad, logic mr);
        exp_t e = '{default: '0};
        if (s.busy) begin
            e.busy   = 1'b1;
            e.grant  = 4'b0001 << s.g;
            e.mvalid = bit_of(v, s.g);
            e.ready  = mr ? (4'b0001 << s.g) : 4'b0000;
            e.wr     = bit_of(wr, s.g);
            e.wsize  = 2'(ws >> (2 * s.g));
            e.aincr  = bit_of(ai, s.g);
            e.size   = 8'(sz >> (8 * s.g));
            e.addr   = 32'(ad >> (32 * s.g));
        end
        return e;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && ma.busy && bit_of(4'(a_valid), ma.g) && a_mready) hs_a.push_back(int'(ma.g));
        ma <= step(ma, 2, rst, 4'(a_valid), a_mready);
        mb <= step(mb, 3, rst, 4'(b_valid), b_mready);
    end

    always @(negedge clk) begin : cmp
        exp_t ea, eb;
        if (cyc > 0) begin
            ea = expect_out(ma, 4'(a_valid), 4'(a_wr), 8'(a_wsize), 4'(a_aincr),
                            32'(a_size), 128'(a_addr), a_mready);
            eb = expect_out(mb, 4'(b_valid), 4'(b_wr), 8'(b_wsize), 4'(b_aincr),
                            32'(b_size), 128'(b_addr), b_mready);
            chk("A.busy",   64'(a_busy),   64'(ea.busy));
            chk("A.grant",  64'(a_grant),  64'(ea.grant));
            chk("A.mvalid", 64'(a_mvalid), 64'(ea.mvalid));
            chk("A.ready",  64'(a_ready),  64'(ea.ready));
            chk("A.fields", {a_mwr, a_mwsize, a_maincr, a_msize, a_maddr},
                            64'({ea.wr, ea.wsize, ea.aincr, ea.size, ea.addr}));
            chk("B.busy",   64'(b_busy),   64'(eb.busy));
            chk("B.grant",  64'(b_grant),  64'(eb.grant));
            chk("B.mvalid", 64'(b_mvalid), 64'(eb.mvalid));
            chk("B.ready",  64'(b_ready),  64'(eb.ready));
            chk("B.fields", {b_mwr, b_mwsize, b_maincr, b_msize, b_maddr},
                            64'({eb.wr, eb.wsize, eb.aincr, eb.size, eb.addr}));
            if (a_mvalid && a_mready) gq_a.push_back(int'(a_grant));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

`ifdef MREQ_ARB_FIXED_PRIO_EN
    int exp_cont_idx[4]  = '{0, 0, 0, 0};
    int exp_cont_gnt[4]  = '{1, 1, 1, 1};
    logic [1:0] exp_abort_gnt = 2'b01;
`else
    int exp_cont_idx[4]  = '{0, 1, 0, 1};
    int exp_cont_gnt[4]  = '{1, 2, 1, 2};
    logic [1:0] exp_abort_gnt = 2'b10;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_valid = '1; a_wr = '0; a_wsize = '0; a_aincr = '0; a_size = '0; a_addr = '0; a_mready = 1'b0;
        b_valid = '1; b_wr = '0; b_wsize = '0; b_aincr = '0; b_size = '0; b_addr = '0; b_mready = 1'b0;

        // Reset held two cycles with all requests valid.
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("rst.A.mvalid", 64'(a_mvalid), 64'd0);
            chk("rst.A.grant",  64'(a_grant),  64'd0);
            chk("rst.A.busy",   64'(a_busy),   64'd0);
            chk("rst.B.mvalid", 64'(b_mvalid), 64'd0);
            chk("rst.B.grant",  64'(b_grant),  64'd0);
        end
        rst = 1'b0; a_valid = '0; b_valid = '0;
        tick;

        // Single request from requester 1.
        a_addr = {32'h1000_0040, 32'h0}; a_size = {8'h10, 8'h00}; a_wr = 2'b10;
        a_wsize = 4'b1000; a_aincr = 2'b10; a_valid = 2'b10; a_mready = 1'b1;
        #1;
        chk("single.idle_mvalid", 64'(a_mvalid), 64'd0);
        tick;
        chk("single.mvalid", 64'(a_mvalid), 64'd1);
        chk("single.addr",   64'(a_maddr),  64'h1000_0040);
        chk("single.size",   64'(a_msize),  64'h10);
        chk("single.wr",     64'(a_mwr),    64'd1);
        chk("single.wsize",  64'(a_mwsize), 64'd2);
        chk("single.ready",  64'(a_ready),  64'b10);
        chk("single.grant",  64'(a_grant),  64'b10);
        tick;
        a_valid = '0;
        #1;
        chk("single.busy_after", 64'(a_busy), 64'd0);
        chk("single.model_hs", 64'(hs_a.size() > 0 ? hs_a[0] : 99), 64'd1);

        // Contention: both valid for four transfers.
        hs_a.delete(); gq_a.delete();
        a_addr = {32'h2000_0000, 32'h1000_0000}; a_wr = 2'b01; a_valid = 2'b11;
        repeat (8) tick;
        a_valid = '0;
        tick;
        chk("cont.count", 64'(gq_a.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("cont.dut_grant", 64'(i < gq_a.size() ? gq_a[i] : 99), 64'(exp_cont_gnt[i]));
            chk("cont.model_idx", 64'(i < hs_a.size() ? hs_a[i] : 99), 64'(exp_cont_idx[i]));
        end

        // Backpressure: req0 held for 20 cycles while req1 waits.
        gq_a.delete();
        a_addr = {32'hB000_0004, 32'hA000_0008}; a_size = {8'h22, 8'h11};
        a_valid = 2'b01; a_mready = 1'b0;
        tick;
        a_valid = 2'b11;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("bp.grant",  64'(a_grant),  64'b01);
            chk("bp.addr",   64'(a_maddr),  64'hA000_0008);
            chk("bp.ready",  64'(a_ready),  64'b00);
            tick;
        end
        a_mready = 1'b1;
        #1;
        chk("bp.ready_release", 64'(a_ready), 64'b01);
        tick;
        a_valid = 2'b10;
        tick;
        chk("bp.req1_grant", 64'(a_grant), 64'b10);
        chk("bp.req1_addr",  64'(a_maddr), 64'hB000_0004);
        tick;
        a_valid = '0;
        tick;
        chk("bp.order0", 64'(gq_a.size() > 0 ? gq_a[0] : 99), 64'd1);
        chk("bp.order1", 64'(gq_a.size() > 1 ? gq_a[1] : 99), 64'd2);

        // Abort: requester 0 drops valid while granted, req1 pending.
        gq_a.delete();
        a_valid = 2'b01; a_mready = 1'b0;
        tick;
        a_valid = 2'b10;
        #1;
        chk("abort.busy",   64'(a_busy),   64'd1);
        chk("abort.mvalid", 64'(a_mvalid), 64'd0);
        tick;
        a_valid = 2'b11;
        #1;
        chk("abort.idle", 64'(a_busy), 64'd0);
        tick;
        chk("abort.next_grant", 64'(a_grant), 64'(exp_abort_gnt));
        chk("abort.no_hs", 64'(gq_a.size()), 64'd0);
        a_mready = 1'b1;
        tick;
        a_valid = '0;
        tick;

        // Reset while granted abandons the grant.
        a_valid = 2'b01; a_mready = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        chk("rstgnt.busy",   64'(a_busy),   64'd0);
        chk("rstgnt.grant",  64'(a_grant),  64'd0);
        chk("rstgnt.mvalid", 64'(a_mvalid), 64'd0);
        rst = 1'b0; a_valid = '0;
        tick;

        // Wrap on the three-requester instance.
        b_addr = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
        b_size = {8'h30, 8'h20, 8'h10}; b_wsize = 6'b10_01_00; b_aincr = 3'b101;
        b_valid = 3'b100; b_mready = 1'b1;
        tick;
        chk("wrap.grant2", 64'(b_grant), 64'b100);
        chk("wrap.addr2",  64'(b_maddr), 64'h3333_0000);
        chk("wrap.wsize2", 64'(b_mwsize), 64'd2);
        tick;
        b_valid = 3'b011;
        #1;
        chk("wrap.model_ptr", 64'(mb.ptr), 64'd0);
        tick;
        chk("wrap.grant0", 64'(b_grant), 64'b001);
        chk("wrap.size0",  64'(b_msize), 64'h10);
        tick;
        b_valid = 3'b010;
        tick;
        chk("wrap.grant1", 64'(b_grant), 64'b010);
        tick;
        b_valid = '0;
        tick;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
